regfile_mp: RTL

Parametrised multi-port register file for the multi-cycle/state-machine CPU datapath.
- Provides NUM_RD registered read ports and two write ports (A: ALU writeback, B: load/multicycle writeback).
- Optional same-cycle write-to-read bypass and an optional hardwired zero register.
- Holds a per-register busy scoreboard so the control FSM can detect pending results.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_scoreboard.sv | 47 ++++
 rtl/regfile_mp.sv | 108 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default widths and
// the helper that locates a port's slice inside a packed port bus.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_RD_MAX = 4;
    localparam int DEPTH      = 2**ADDR_W_DEF;

    // Low bit of port 'idx' in a bus made of 'width'-bit fields.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard. A write retires a pending result and
// bsy_set marks a new one. Sets are applied after clears, so a producer that
// issues in the same cycle as the old result lands keeps the register busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wa_en,
    input  logic [ADDR_W-1:0]      wa_addr,
    input  logic                   wb_en,
    input  logic [ADDR_W-1:0]      wb_addr,
    input  logic                   bsy_set,
    input  logic [ADDR_W-1:0]      bsy_addr,
    output logic [2**ADDR_W-1:0]   busy_q,
    output logic [2**ADDR_W-1:0]   busy_nxt,
    output logic                   any_busy
);

    logic set_ok;

    // Register 0 can never hold a pending result when it is hardwired to zero.
    assign set_ok = bsy_set && !((ZERO_REG != 0) && (bsy_addr == '0));

    // Busy next-state: clear for port A, clear for port B, then set.
    always_comb begin
        busy_nxt = busy_q;
        if (wa_en) busy_nxt[wa_addr] = 1'b0;
        if (wb_en) busy_nxt[wb_addr] = 1'b0;
        if (set_ok) busy_nxt[bsy_addr] = 1'b1;
    end

    // Busy vector and its registered OR-reduction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            any_busy <= 1'b0;
        end else begin
            busy_q   <= busy_nxt;
            any_busy <= |busy_nxt;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports (B has priority over A on an
// address collision), NUM_RD registered read ports with optional same-cycle
// bypass, optional hardwired zero register, and a busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wa_en,
    input  logic [ADDR_W-1:0]          wa_addr,
    input  logic [DATA_W-1:0]          wa_data,
    input  logic                       wb_en,
    input  logic [ADDR_W-1:0]          wb_addr,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic                       bsy_set,
    input  logic [ADDR_W-1:0]          bsy_addr,
    output logic                       any_busy
);

    localparam int N_REGS = 2**ADDR_W;

    logic [DATA_W-1:0] mem [N_REGS];
    logic [N_REGS-1:0] sb_busy;
    logic [N_REGS-1:0] sb_busy_nxt;
    logic              wa_ok;
    logic              wb_ok;

    // Writes to register 0 are dropped when it is hardwired to zero.
    assign wa_ok = wa_en && !((ZERO_REG != 0) && (wa_addr == '0));
    assign wb_ok = wb_en && !((ZERO_REG != 0) && (wb_addr == '0));

    // Storage: port B is assigned last so it wins a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N_REGS; r++) mem[r] <= '0;
        end else begin
            if (wa_ok) mem[wa_addr] <= wa_data;
            if (wb_ok) mem[wb_addr] <= wb_data;
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .wa_en    (wa_en),
        .wa_addr  (wa_addr),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .bsy_set  (bsy_set),
        .bsy_addr (bsy_addr),
        .busy_q   (sb_busy),
        .busy_nxt (sb_busy_nxt),
        .any_busy (any_busy)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data_d;
        logic [DATA_W-1:0] data_q;
        logic              busy_d;
        logic              busy_r;

        assign addr = rd_addr[slice_lo(i, ADDR_W) +: ADDR_W];

        // Read value: stored contents, or post-edge contents when bypassing.
        always_comb begin
            data_d = mem[addr];
            busy_d = sb_busy[addr];
            if (BYPASS != 0) begin
                busy_d = sb_busy_nxt[addr];
                if (wa_ok && (wa_addr == addr)) data_d = wa_data;
                if (wb_ok && (wb_addr == addr)) data_d = wb_data;
            end
            if ((ZERO_REG != 0) && (addr == '0)) begin
                data_d = '0;
                busy_d = 1'b0;
            end
        end

        // Read port register: loads on rd_en, otherwise holds.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q <= '0;
                busy_r <= 1'b0;
            end else if (rd_en[i]) begin
                data_q <= data_d;
                busy_r <= busy_d;
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = data_q;
        assign rd_busy[i]                  = busy_r;
    end

endmodule
